snake_score_ctrl: RTL and testbench

SNAKE_SCORE_CTRL -- requirements
Module: snake_score_ctrl

---
 rtl/snake_pkg.sv | 17 +
 rtl/snake_bcd_inc.sv | 32 +++
 rtl/snake_score_ctrl.sv | 135 +++++++++++++
 tb/tb_snake_score_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared constants for the snake scoreboard: FSM encoding, BCD digit geometry
// and the score limits used by the controller and its BCD incrementer.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;

  localparam logic [15:0] SCORE_MAX  = 16'h9999;
  localparam logic [15:0] SCORE_ZERO = 16'h0000;

endpackage

// File: rtl/snake_bcd_inc.sv
// Combinational 4-digit packed-BCD incrementer that saturates at 9999.
module snake_bcd_inc
  import snake_pkg::*;
(
  input  logic [DIGIT_W*NUM_DIGITS-1:0] i_value,
  output logic [DIGIT_W*NUM_DIGITS-1:0] o_value
);

  logic               carry;
  logic [DIGIT_W-1:0] digit;

  always_comb begin
    o_value = i_value;
    carry   = 1'b1;
    digit   = '0;
    if (i_value != SCORE_MAX) begin
      // Ripple the +1 upward: a 9 rolls to 0 and keeps the carry alive.
      for (int d = 0; d < NUM_DIGITS; d++) begin
        digit = i_value[d*DIGIT_W +: DIGIT_W];
        if (carry) begin
          if (digit >= 4'd9) begin
            o_value[d*DIGIT_W +: DIGIT_W] = '0;
          end else begin
            o_value[d*DIGIT_W +: DIGIT_W] = digit + 4'd1;
            carry                         = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/snake_score_ctrl.sv
// Snake game score controller: score/high-score tracking and scoreboard display mux.
// Optional feature macro: SNAKE_HISCORE_EN (high score and OVER-state alternation).
module snake_score_ctrl
  import snake_pkg::*;
#(
  parameter int ALT_PERIOD  = 50_000_000,
  parameter int SCORE_WIDTH = 16
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_NewGame,
  input  logic                   i_Eat,
  input  logic                   i_GameOver,
  output logic [SCORE_WIDTH-1:0] o_Score,
  output logic [SCORE_WIDTH-1:0] o_HighScore,
  output logic [SCORE_WIDTH-1:0] o_DisplayValue,
  output logic                   o_ShowingHigh,
  output logic                   o_Playing,
  output logic [1:0]             o_State
);

  // Inputs are single-cycle pulses sampled on the rising edge; no handshake.
  state_t                 state_q, state_d;
  logic [SCORE_WIDTH-1:0] score_q, score_d;
  logic [SCORE_WIDTH-1:0] disp_q, disp_d;
  logic                   playing_q, playing_d;
  logic [SCORE_WIDTH-1:0] inc_value;

`ifdef SNAKE_HISCORE_EN
  localparam int CNT_W = (ALT_PERIOD > 1) ? $clog2(ALT_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALT_PERIOD - 1);

  logic [SCORE_WIDTH-1:0] high_q, high_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   show_q, show_d;
`endif

  snake_bcd_inc u_bcd_inc (
    .i_value (score_q),
    .o_value (inc_value)
  );

  always_comb begin
    state_d = state_q;
    score_d = score_q;
`ifdef SNAKE_HISCORE_EN
    high_d  = high_q;
`endif
    // Priority: new game, then game over, then eat.
    case (state_q)
      ST_IDLE: begin
        if (i_NewGame) begin
          state_d = ST_PLAY;
          score_d = SCORE_ZERO;
        end
      end
      ST_PLAY: begin
        if (i_NewGame) begin
          score_d = SCORE_ZERO;
        end else if (i_GameOver) begin
          state_d = ST_OVER;
`ifdef SNAKE_HISCORE_EN
          if (score_q > high_q) high_d = score_q;
`endif
        end else if (i_Eat) begin
          score_d = inc_value;
        end
      end
      ST_OVER: begin
        if (i_NewGame) begin
          state_d = ST_PLAY;
          score_d = SCORE_ZERO;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    playing_d = (state_d == ST_PLAY);

`ifdef SNAKE_HISCORE_EN
    // Phase counter runs only while staying in OVER; entering OVER starts at 0.
    cnt_d  = '0;
    show_d = 1'b0;
    if (state_q == ST_OVER && state_d == ST_OVER) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        show_d = ~show_q;
      end else begin
        cnt_d  = cnt_q + 1'b1;
        show_d = show_q;
      end
    end
    disp_d = show_d ? high_d : score_d;
`else
    disp_d = score_d;
`endif
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      score_q   <= SCORE_ZERO;
      disp_q    <= SCORE_ZERO;
      playing_q <= 1'b0;
`ifdef SNAKE_HISCORE_EN
      high_q    <= SCORE_ZERO;
      cnt_q     <= '0;
      show_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      disp_q    <= disp_d;
      playing_q <= playing_d;
`ifdef SNAKE_HISCORE_EN
      high_q    <= high_d;
      cnt_q     <= cnt_d;
      show_q    <= show_d;
`endif
    end
  end

  assign o_Score        = score_q;
  assign o_DisplayValue = disp_q;
  assign o_Playing      = playing_q;
  assign o_State        = state_q;
`ifdef SNAKE_HISCORE_EN
  assign o_HighScore    = high_q;
  assign o_ShowingHigh  = show_q;
`else
  assign o_HighScore    = '0;
  assign o_ShowingHigh  = 1'b0;
`endif

endmodule

// File: tb/tb_snake_score_ctrl.sv
// Directed bench for snake_score_ctrl with a behavioural score model and expected queue.
module tb_snake_score_ctrl;
  import snake_pkg::*;

  localparam int ALT = 4;

  logic        i_Clk = 1'b0;
  logic        i_Reset = 1'b0;
  logic        i_NewGame = 1'b0;
  logic        i_Eat = 1'b0;
  logic        i_GameOver = 1'b0;
  logic [15:0] o_Score;
  logic [15:0] o_HighScore;
  logic [15:0] o_DisplayValue;
  logic        o_ShowingHigh;
  logic        o_Playing;
  logic [1:0]  o_State;

  snake_score_ctrl #(
    .ALT_PERIOD  (ALT),
    .SCORE_WIDTH (16)
  ) dut (
    .i_Clk          (i_Clk),
    .i_Reset        (i_Reset),
    .i_NewGame      (i_NewGame),
    .i_Eat          (i_Eat),
    .i_GameOver     (i_GameOver),
    .o_Score        (o_Score),
    .o_HighScore    (o_HighScore),
    .o_DisplayValue (o_DisplayValue),
    .o_ShowingHigh  (o_ShowingHigh),
    .o_Playing      (o_Playing),
    .o_State        (o_State)
  );

  // Clock
  always #5 i_Clk = ~i_Clk;

  int total = 0;
  int bad   = 0;

  // {score, high, disp, show, playing, state}
  logic [51:0] exp_q[$];

  state_t m_state = ST_IDLE;
  int     m_score = 0;
  int     m_high  = 0;
  int     m_phase = 0;
  logic   m_show  = 1'b0;

  logic [15:0] disp_seq[9];
  logic [15:0] disp_want[9];

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic model_step(input logic rst, input logic ng, input logic eat, input logic go);
    if (rst) begin
      m_state = ST_IDLE; m_score = 0; m_high = 0; m_phase = 0; m_show = 1'b0;
    end else if (ng) begin
      m_state = ST_PLAY; m_score = 0; m_phase = 0; m_show = 1'b0;
    end else if (m_state == ST_PLAY) begin
      if (go) begin
        m_state = ST_OVER;
        if (m_score > m_high) m_high = m_score;
        m_phase = 0; m_show = 1'b0;
      end else if (eat) begin
        if (m_score < 9999) m_score++;
      end
    end else if (m_state == ST_OVER) begin
      if (m_phase == ALT - 1) begin
        m_phase = 0; m_show = ~m_show;
      end else begin
        m_phase++;
      end
    end
  endtask

  task automatic push_expected();
    logic [15:0] e_score, e_high, e_disp;
    logic        e_show;
    e_score = to_bcd(m_score);
`ifdef SNAKE_HISCORE_EN
    e_high = to_bcd(m_high);
    e_show = (m_state == ST_OVER) && m_show;
`else
    e_high = 16'h0000;
    e_show = 1'b0;
`endif
    e_disp = e_show ? e_high : e_score;
    exp_q.push_back({e_score, e_high, e_disp, e_show, m_state == ST_PLAY, 2'(m_state)});
  endtask

  task automatic check_outputs();
    logic [51:0] e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $error("FAIL scoreboard_empty got=0 want=1");
    end else begin
      e = exp_q.pop_front();
      chk("score",   o_Score,                 e[51:36]);
      chk("high",    o_HighScore,             e[35:20]);
      chk("disp",    o_DisplayValue,          e[19:4]);
      chk("show",    {15'd0, o_ShowingHigh},  {15'd0, e[3]});
      chk("playing", {15'd0, o_Playing},      {15'd0, e[2]});
      chk("state",   {14'd0, o_State},        {14'd0, e[1:0]});
    end
  endtask

  // Driver: one clock per step, outputs sampled 1 time unit after the edge.
  task automatic step(input logic rst, input logic ng, input logic eat, input logic go);
    i_Reset = rst; i_NewGame = ng; i_Eat = eat; i_GameOver = go;
    model_step(rst, ng, eat, go);
    push_expected();
    @(posedge i_Clk);
    #1;
    i_Reset = 1'b0; i_NewGame = 1'b0; i_Eat = 1'b0; i_GameOver = 1'b0;
    check_outputs();
  endtask

  task automatic eat_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and idle behaviour
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_score", o_Score, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("idle_eat_ignored", o_Score, 16'h0000);

    // Start and three points
    step(1'b0, 1'b1, 1'b0, 1'b0);
    eat_n(3);
    chk("three_eats", o_Score, 16'h0003);
    chk("three_eats_playing", {15'd0, o_Playing}, 16'd1);

    // Digit carry 0099 -> 0100
    eat_n(96);
    chk("at_0099", o_Score, 16'h0099);
    eat_n(1);
    chk("carry_0100", o_Score, 16'h0100);

    // New game mid-play wins over eat
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("restart_clears", o_Score, 16'h0000);

    // Eat and game over together at score 5
    eat_n(5);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("go_eat_state", {14'd0, o_State}, {14'd0, ST_OVER});
    chk("go_eat_score", o_Score, 16'h0005);
`ifdef SNAKE_HISCORE_EN
    chk("go_eat_high", o_HighScore, 16'h0005);
`else
    chk("go_eat_high", o_HighScore, 16'h0000);
`endif

    // Build high score 7, then end a game at 2 and watch the display alternate
    step(1'b0, 1'b1, 1'b0, 1'b0);
    eat_n(7);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    eat_n(2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    disp_seq[0] = o_DisplayValue;
    for (int i = 1; i < 9; i++) begin
      step(1'b0, 1'b0, (i % 3) == 1, (i % 4) == 2);
      disp_seq[i] = o_DisplayValue;
    end
    for (int i = 0; i < 9; i++) begin
`ifdef SNAKE_HISCORE_EN
      disp_want[i] = (i >= 4 && i < 8) ? 16'h0007 : 16'h0002;
`else
      disp_want[i] = 16'h0002;
`endif
      chk($sformatf("alt_disp_%0d", i), disp_seq[i], disp_want[i]);
    end

    // Second game ends at 3; high score must stay 7
    step(1'b0, 1'b1, 1'b0, 1'b0);
    eat_n(3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
`ifdef SNAKE_HISCORE_EN
    chk("high_kept", o_HighScore, 16'h0007);
`else
    chk("high_kept", o_HighScore, 16'h0000);
`endif
    chk("over_disp_score", o_DisplayValue, 16'h0003);

    // Reset mid-play at score 42
    step(1'b0, 1'b1, 1'b0, 1'b0);
    eat_n(42);
    chk("at_0042", o_Score, 16'h0042);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("rst_score", o_Score, 16'h0000);
    chk("rst_high", o_HighScore, 16'h0000);
    chk("rst_disp", o_DisplayValue, 16'h0000);
    chk("rst_state", {14'd0, o_State}, {14'd0, ST_IDLE});

    // Saturation at 9999
    step(1'b0, 1'b1, 1'b0, 1'b0);
    eat_n(9999);
    chk("at_9999", o_Score, 16'h9999);
    eat_n(2);
    chk("saturate_9999", o_Score, 16'h9999);
    chk("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
